// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, run/step/halt FSM and redirect selection.
// Optional advance-cycle counter enabled by defining FETCH_CTRL_CYCLE_CNT_EN.
module fetch_ctrl #(
  parameter int            NB       = 32,
  parameter logic [NB-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic          i_step,
  input  logic          i_stall,
  input  logic          i_halt,
  input  logic          i_branch,
  input  logic          i_jump,
  input  logic          i_jr_jalr,
  input  logic [NB-1:0] i_branch_addr,
  input  logic [NB-1:0] i_jump_addr,
  input  logic [NB-1:0] i_jr_jalr_addr,
  output logic [NB-1:0] o_pc,
  output logic [NB-1:0] o_pc4,
  output logic          o_advance,
  output logic          o_flush,
  output logic [1:0]    o_state,
  output logic          o_halted,
  output logic [31:0]   o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [NB-1:0] pc_q, pc_d;
  logic          halted_q;
  logic          active;
  logic          redirect;
  logic          halt_req;
  logic          advance;

  always_comb begin
    active   = (state_q == RUN) || ((state_q == STEP) && i_step);
    redirect = i_branch || i_jump || i_jr_jalr;
    // A halt decoded alongside a redirect is on the wrong path and is dropped.
    halt_req = active && i_halt && !redirect;
    advance  = active && (!i_stall || redirect) && !halt_req;
  end

  always_comb begin
    pc_d = pc_q + NB'(4);
    if (i_branch)       pc_d = i_branch_addr;
    else if (i_jump)    pc_d = i_jump_addr;
    else if (i_jr_jalr) pc_d = i_jr_jalr_addr;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = i_mode ? STEP : RUN;
      RUN,
      STEP: if (halt_req) state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      if (advance) pc_q <= pc_d;
    end
  end

`ifdef FETCH_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  // Saturates so a long run never wraps back to a small count.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      cycle_cnt_q <= '0;
    else if (advance && (cycle_cnt_q != 32'hFFFF_FFFF))
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = 32'd0;
`endif

  assign o_pc      = pc_q;
  assign o_pc4     = pc_q + NB'(4);
  assign o_advance = advance;
  assign o_flush   = advance && redirect;
  assign o_state   = state_q;
  assign o_halted  = halted_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter NB, default 32: PC and address width.
REQ-002 Parameter RESET_PC, default 0: PC value after reset.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  debug-unit start pulse; sampled only in IDLE.
REQ-006 i_mode  in  1  0 = continuous run, 1 = step mode; sampled with i_start.
REQ-007 i_step  in  1  debug-unit step pulse; honoured only in STEP.
REQ-008 i_stall  in  1  hazard-unit stall request.
REQ-009 i_halt  in  1  HALT instruction decoded at current o_pc.
REQ-010 i_branch, i_jump, i_jr_jalr  in  1 each  redirect requests.
REQ-011 i_branch_addr, i_jump_addr, i_jr_jalr_addr  in  NB each  redirect targets.
REQ-012 o_pc  out  NB  registered program counter.
REQ-013 o_pc4  out  NB  o_pc + 4, combinational.
REQ-014 o_advance  out  1  combinational; PC and IF/ID register load this cycle.
REQ-015 o_flush  out  1  combinational; squash IF/ID contents this cycle.
REQ-016 o_state  out  2  current FSM state encoding.
REQ-017 o_halted  out  1  registered; 1 in HALT.
REQ-018 o_cycle_count  out  32  count of advance cycles.

Function
REQ-019 States SHALL be IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
REQ-020 IDLE: i_start & !i_mode -> RUN; i_start & i_mode -> STEP; otherwise hold; PC frozen.
REQ-021 active SHALL be (state==RUN) | (state==STEP & i_step).
REQ-022 redirect SHALL be i_branch | i_jump | i_jr_jalr.
REQ-023 o_advance SHALL be active & (!i_stall | redirect); a redirect overrides a stall so no control transfer is lost.
REQ-024 Next PC priority: i_branch -> i_branch_addr, else i_jump -> i_jump_addr, else i_jr_jalr -> i_jr_jalr_addr, else o_pc4.
REQ-025 On o_advance, o_pc SHALL load next PC on the following edge; otherwise o_pc holds.
REQ-026 o_flush SHALL be o_advance & redirect.
REQ-027 Halt: in RUN/STEP, active & i_halt & !redirect -> HALT next edge; PC not advanced, o_advance forced 0 that cycle.
REQ-028 i_halt with simultaneous redirect is wrong-path: redirect taken, no transition to HALT.
REQ-029 HALT SHALL be exited only by reset; all inputs ignored.
REQ-030 i_step outside STEP and i_start outside IDLE SHALL be ignored.
REQ-031 o_pc4 SHALL wrap modulo 2^NB (0xFFFFFFFC + 4 = 0x0).
REQ-032 o_halted SHALL equal (state==HALT), registered.

Reset
REQ-033 On i_reset high at an edge: state=IDLE, o_pc=RESET_PC, o_halted=0, o_cycle_count=0; o_advance=o_flush=0 while in IDLE.
REQ-034 Reset SHALL take priority over all inputs, including mid-run and mid-redirect.

Configuration
REQ-035 Macro FETCH_CTRL_CYCLE_CNT_EN defined: o_cycle_count SHALL increment by 1 on every edge where o_advance=1, saturating at 0xFFFFFFFF.
REQ-036 Macro undefined: no counter register; o_cycle_count SHALL be tied to 0; port retained.

Verification
REQ-037 Reset, i_start=1 i_mode=0, 4 idle cycles -> o_pc 0,4,8,12,16; o_state=01; counter=4 (macro on).
REQ-038 RUN, i_stall=1 two cycles at o_pc=0x10 -> o_pc holds 0x10, o_advance=0; then i_stall=0 -> 0x14.
REQ-039 RUN, i_stall=1 with i_jump=1 i_jump_addr=0x40 and i_branch=1 i_branch_addr=0x80 -> o_pc=0x80, o_flush=1 one cycle.
REQ-040 STEP mode, i_step pulses at cycles 3 and 7 only -> o_pc changes exactly twice, 0->4->8.
REQ-041 RUN, i_halt=1 at o_pc=0x20 -> o_state=11, o_halted=1, o_pc stays 0x20 for 10 cycles despite i_start/i_step; i_halt with i_jr_jalr=1 addr 0x100 -> o_pc=0x100, no halt.
REQ-042 Reset asserted in HALT -> next edge state=IDLE, o_pc=RESET_PC, o_cycle_count=0.
